dcache_maint_engine: RTL
========================

// Module: dcache_maint_engine
// PURPOSE
//  Cache-side responder for the dcache clear/flush handshake driven by the pipeline.
//  On a request it walks every set/way of the L1 dcache's tag array. Clear invalidates
//  each line; flush first writes back dirty lines over the memory bus, then invalidates.
//  It reports completion on dclear_done/dflush_done. Sits inside the L1 dcache beside
//  the main lookup FSM; it owns the tag/data arrays while busy is high.
// PARAMETERS
//  NUM_SETS        64  sets in dcache (power of 2, >=2)
//  ASSOC           2   ways per set (power of 2, >=1)
//  WORDS_PER_LINE  4   32-bit words per line (power of 2, >=2)
//  ADDR_W          32  byte address width; TAG_W = ADDR_W - log2(NUM_SETS) - log2(WORDS_PER_LINE) - 2
// PORTS
//  CLK            in   1       clock, rising edge
//  RST            in   1       synchronous, active-high reset
//  dcache_clear   in   1       clear request, held by pipeline until dclear_done
//  dcache_flush   in   1       flush request, held by pipeline until dflush_done
//  dclear_done    out  1       clear complete
//  dflush_done    out  1       flush complete
//  busy           out  1       engine owns arrays; main FSM must stall
//  meta_set       out  SETW    set index for tag/data access
//  meta_way       out  WAYW    way index (WAYW = max(1, log2 ASSOC))
//  meta_rd        out  1       tag read strobe; result valid next cycle
//  meta_valid     in   1       valid bit of addressed line
//  meta_dirty     in   1       dirty bit of addressed line
//  meta_tag       in   TAG_W   tag of addressed line
//  meta_inval     out  1       write valid=0, dirty=0 to addressed line this cycle
//  data_rd        out  1       data word read strobe; data_rdata valid next cycle
//  data_word      out  WDW     word offset within line
//  data_rdata     in   32      read data
//  mem_wen        out  1       bus write request (bus_ctrl style), held until accepted
//  mem_addr       out  ADDR_W  {meta_tag, meta_set, data_word, 2'b00}
//  mem_wdata      out  32      write data
//  mem_busy       in   1       bus busy; write accepted on cycle mem_wen && !mem_busy
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; set/way/word counters 0.
//  FSM:
//   IDLE: leave when dcache_flush or dcache_clear is high.
//     Latch mode: flush if dcache_flush, else clear (both high -> flush). Go to RD.
//   RD: meta_rd=1 for current set/way. Go to CHK.
//   CHK: if mode==flush && meta_valid && meta_dirty: latch tag, word=0, go to DRD;
//     else go to INV.
//   DRD: data_rd=1 for current word. Go to WR.
//   WR: mem_wen=1; addr and data held stable until accepted.
//     On accept: last word -> INV; else word+1 -> DRD.
//   INV: meta_inval=1. Advance way, then set, with wrap.
//     Last set and last way -> DONE; else -> RD.
//   DONE: busy=0. Assert dflush_done (flush mode) or dclear_done (clear mode).
//     Flush mode: if dcache_clear is also high, assert dclear_done too.
//     Done stays high while the corresponding request is high.
//     All requests low -> IDLE next cycle, done low.
//  busy=1 in every state except IDLE and DONE.
//  Mode is sampled once in IDLE; request changes mid-walk are ignored.
//  The walk always completes.
//  Latency, no dirty lines: 3*NUM_SETS*ASSOC cycles from request to done (done on the next cycle).
//  Each dirty line on flush adds 2*WORDS_PER_LINE cycles plus mem_busy stall cycles.
//  RST mid-walk: IDLE next cycle, outputs 0, no further array/bus activity.
//  A later request restarts at set 0, way 0.
//  Lines already invalidated before the reset stay invalid.
// TESTING
//  1. Defaults, all lines clean, dcache_clear=1 -> 128 meta_inval pulses, no mem_wen.
//     dclear_done rises exactly 385 cycles after the request.
//  2. Flush with set 5, way 1 dirty, tag 0x12345; other lines clean ->
//     4 writes to 0x048D1450/454/458/45C in order, then INV of that line.
//     dflush_done after 393 cycles.
//  3. Case 2 with mem_busy high for 3 cycles on each write ->
//     mem_wen/addr/wdata stable while stalled; done 12 cycles later (405).
//  4. dcache_clear and dcache_flush high together, one dirty line -> writeback occurs.
//     Both dones assert together in DONE.
//  5. RST pulsed during the 2nd WR of case 2 -> next cycle all outputs 0.
//     A re-issued flush starts with meta_set=0, meta_way=0.
//  6. Done held 10 cycles while request held. Request dropped -> done 0 next cycle, busy 0.
//     Re-request starts a fresh full walk.

Source files
------------

// File: rtl/dcache_maint_engine.sv
// Dcache clear/flush maintenance engine: walks every set/way of the tag array,
// writes back dirty lines over the memory bus on flush, and invalidates every line.
module dcache_maint_engine #(
    parameter int  NUM_SETS       = 64,
    parameter int  ASSOC          = 2,
    parameter int  WORDS_PER_LINE = 4,
    parameter int  ADDR_W         = 32,
    localparam int SETW           = $clog2(NUM_SETS),
    localparam int WAYW           = (ASSOC > 1) ? $clog2(ASSOC) : 1,
    localparam int WDW            = $clog2(WORDS_PER_LINE),
    localparam int TAG_W          = ADDR_W - SETW - WDW - 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dcache_clear,
    input  logic              dcache_flush,
    output logic              dclear_done,
    output logic              dflush_done,
    output logic              busy,
    output logic [SETW-1:0]   meta_set,
    output logic [WAYW-1:0]   meta_way,
    output logic              meta_rd,
    input  logic              meta_valid,
    input  logic              meta_dirty,
    input  logic [TAG_W-1:0]  meta_tag,
    output logic              meta_inval,
    output logic              data_rd,
    output logic [WDW-1:0]    data_word,
    input  logic [31:0]       data_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CHK, S_DRD, S_WR, S_INV, S_DONE
    } state_t;

    localparam logic [SETW-1:0] SET_LAST  = SETW'(NUM_SETS - 1);
    localparam logic [WAYW-1:0] WAY_LAST  = WAYW'(ASSOC - 1);
    localparam logic [WDW-1:0]  WORD_LAST = WDW'(WORDS_PER_LINE - 1);

    state_t             state_q, state_d;
    logic               flush_mode_q;
    logic [SETW-1:0]    set_q;
    logic [WAYW-1:0]    way_q;
    logic [WDW-1:0]     word_q;
    logic [TAG_W-1:0]   tag_q;
    logic [31:0]        wdata_q;
    logic               wr_first_q;

    assign meta_set  = set_q;
    assign meta_way  = way_q;
    assign data_word = word_q;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            flush_mode_q <= 1'b0;
            set_q        <= '0;
            way_q        <= '0;
            word_q       <= '0;
            tag_q        <= '0;
            wdata_q      <= '0;
            wr_first_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    // Mode follows flush priority; the value present on exit is the one kept.
                    flush_mode_q <= dcache_flush;
                    set_q        <= '0;
                    way_q        <= '0;
                    word_q       <= '0;
                end
                S_CHK: begin
                    tag_q  <= meta_tag;
                    word_q <= '0;
                end
                S_DRD: wr_first_q <= 1'b1;
                S_WR: begin
                    // Read data is only guaranteed on the first WR cycle; hold it through stalls.
                    wr_first_q <= 1'b0;
                    if (wr_first_q) wdata_q <= data_rdata;
                    if (!mem_busy) word_q <= word_q + 1'b1;
                end
                S_INV: begin
                    if (way_q == WAY_LAST) begin
                        way_q <= '0;
                        set_q <= set_q + 1'b1;
                    end else begin
                        way_q <= way_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output and state_d gets a default first so no path infers a latch.
        state_d     = state_q;
        busy        = 1'b0;
        meta_rd     = 1'b0;
        meta_inval  = 1'b0;
        data_rd     = 1'b0;
        mem_wen     = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        dclear_done = 1'b0;
        dflush_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dcache_flush || dcache_clear) state_d = S_RD;
            end
            S_RD: begin
                busy    = 1'b1;
                meta_rd = 1'b1;
                state_d = S_CHK;
            end
            S_CHK: begin
                busy    = 1'b1;
                state_d = (flush_mode_q && meta_valid && meta_dirty) ? S_DRD : S_INV;
            end
            S_DRD: begin
                busy    = 1'b1;
                data_rd = 1'b1;
                state_d = S_WR;
            end
            S_WR: begin
                busy      = 1'b1;
                mem_wen   = 1'b1;
                mem_addr  = {tag_q, set_q, word_q, 2'b00};
                mem_wdata = wr_first_q ? data_rdata : wdata_q;
                if (!mem_busy) state_d = (word_q == WORD_LAST) ? S_INV : S_DRD;
            end
            S_INV: begin
                busy       = 1'b1;
                meta_inval = 1'b1;
                state_d    = (set_q == SET_LAST && way_q == WAY_LAST) ? S_DONE : S_RD;
            end
            S_DONE: begin
                if (flush_mode_q) begin
                    dflush_done = 1'b1;
                    dclear_done = dcache_clear;
                end else begin
                    dclear_done = 1'b1;
                end
                if (!dcache_clear && !dcache_flush) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
